// File: rtl/selector_c_decoder_if.sv
// Observation bus of a selector_c_decoder: sampled selector pins in, identification status out.
interface selector_c_decoder_if;
   logic       start;
   logic       valid;
   logic       a;
   logic       b;
   logic       q;
   logic       nq;
   logic [3:0] cand;
   logic [1:0] sel_out;
   logic       locked;
   logic       busy;
   logic       error;
   logic [1:0] err_code;

   modport master (
      output start, valid, a, b, q, nq,
      input  cand, sel_out, locked, busy, error, err_code
   );

   modport slave (
      input  start, valid, a, b, q, nq,
      output cand, sel_out, locked, busy, error, err_code
   );
endinterface

// File: rtl/selector_c_decoder.sv
// Recovers the 2-bit function select of a selector_c stage from observed a/b/Q/NQ samples,
// narrowing a candidate mask until one code is confirmed, then watching for deviations.
module selector_c_decoder #(
   parameter int LOCK_SAMPLES = 4,
   parameter int MAX_SAMPLES  = 32
) (
   input  logic                 clk,
   input  logic                 rst_n,
   selector_c_decoder_if.slave  bus
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_SEARCH = 2'd1,
      S_LOCKED = 2'd2,
      S_ERROR  = 2'd3
   } state_t;

   localparam logic [3:0] LP_LOCK = 4'(LOCK_SAMPLES);
   localparam logic [7:0] LP_MAX  = 8'(MAX_SAMPLES);

   state_t     r_state;
   logic [3:0] r_cand;
   logic [1:0] r_sel;
   logic       r_locked;
   logic       r_busy;
   logic       r_error;
   logic [1:0] r_err_code;
   logic [7:0] r_smp_cnt;
   logic [3:0] r_cfm_cnt;

   logic [3:0] w_m;
   logic [3:0] w_new;
   logic [3:0] w_cfm_nxt;
   logic [7:0] w_smp_nxt;
   logic       w_cmp_bad;

   function automatic logic [1:0] f_bit_index(input logic [3:0] v);
      logic [1:0] idx;
      idx = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (v[i]) idx = 2'(i);
      end
      return idx;
   endfunction

   // One match bit per select code: does q agree with what that code would produce?
   assign w_m[0]    = (bus.q == bus.a);
   assign w_m[1]    = (bus.q == bus.b);
   assign w_m[2]    = (bus.q == (bus.a & bus.b));
   assign w_m[3]    = (bus.q == (bus.a | bus.b));
   assign w_new     = r_cand & w_m;
   assign w_cmp_bad = (bus.nq == bus.q);
   assign w_cfm_nxt = $onehot(w_new) ? (r_cfm_cnt + 4'd1) : 4'd0;
   assign w_smp_nxt = r_smp_cnt + 8'd1;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= S_IDLE;
         r_cand     <= 4'b1111;
         r_sel      <= 2'b00;
         r_locked   <= 1'b0;
         r_busy     <= 1'b0;
         r_error    <= 1'b0;
         r_err_code <= 2'b00;
         r_smp_cnt  <= 8'd0;
         r_cfm_cnt  <= 4'd0;
      end else if (bus.start) begin
         r_state    <= S_SEARCH;
         r_cand     <= 4'b1111;
         r_sel      <= 2'b00;
         r_locked   <= 1'b0;
         r_busy     <= 1'b1;
         r_error    <= 1'b0;
         r_err_code <= 2'b00;
         r_smp_cnt  <= 8'd0;
         r_cfm_cnt  <= 4'd0;
      end else if (bus.valid) begin
         case (r_state)
            S_SEARCH: begin
               if (w_cmp_bad) begin
                  r_state    <= S_ERROR;
                  r_busy     <= 1'b0;
                  r_error    <= 1'b1;
                  r_err_code <= 2'b01;
               end else if (w_new == 4'b0000) begin
                  r_state    <= S_ERROR;
                  r_cand     <= 4'b0000;
                  r_busy     <= 1'b0;
                  r_error    <= 1'b1;
                  r_err_code <= 2'b10;
               end else begin
                  r_cand    <= w_new;
                  r_smp_cnt <= w_smp_nxt;
                  r_cfm_cnt <= w_cfm_nxt;
                  // Lock wins over timeout when both land on the same sample.
                  if (w_cfm_nxt == LP_LOCK) begin
                     r_state  <= S_LOCKED;
                     r_busy   <= 1'b0;
                     r_locked <= 1'b1;
                     r_sel    <= f_bit_index(w_new);
                  end else if (w_smp_nxt == LP_MAX) begin
                     r_state    <= S_ERROR;
                     r_busy     <= 1'b0;
                     r_error    <= 1'b1;
                     r_err_code <= 2'b11;
                  end
               end
            end
            S_LOCKED: begin
               if (w_cmp_bad) begin
                  r_state    <= S_ERROR;
                  r_locked   <= 1'b0;
                  r_error    <= 1'b1;
                  r_err_code <= 2'b01;
               end else if (!w_m[r_sel]) begin
                  r_state    <= S_ERROR;
                  r_locked   <= 1'b0;
                  r_error    <= 1'b1;
                  r_err_code <= 2'b10;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.cand     = r_cand;
   assign bus.sel_out  = r_sel;
   assign bus.locked   = r_locked;
   assign bus.busy     = r_busy;
   assign bus.error    = r_error;
   assign bus.err_code = r_err_code;

endmodule

// File: tb/tb_selector_c_decoder.sv
// Bench for selector_c_decoder: directed scenarios plus random sample streams against a
// candidate-set reference model built from the selector's function table.
module tb_selector_c_decoder;

   localparam int LK = 4;
   localparam int MX = 8;

   localparam int M_IDLE   = 0;
   localparam int M_SEARCH = 1;
   localparam int M_LOCKED = 2;
   localparam int M_ERROR  = 3;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   selector_c_decoder_if bus_if ();

   selector_c_decoder #(
      .LOCK_SAMPLES(LK),
      .MAX_SAMPLES (MX)
   ) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus_if)
   );

   int checks   = 0;
   int failures = 0;

   int         m_st;
   logic [3:0] m_cand;
   int         m_smp;
   int         m_run;
   logic [1:0] m_sel;
   logic [1:0] m_code;
   bit         m_lk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // What a selector_c stage outputs for a given select code.
   function automatic bit sel_fn(input int c, input bit a, input bit b);
      case (c)
         0:       return a;
         1:       return b;
         2:       return a & b;
         default: return a | b;
      endcase
   endfunction

   task automatic model_reset();
      m_st = M_IDLE; m_cand = 4'b1111; m_smp = 0; m_run = 0;
      m_sel = 2'b00; m_code = 2'b00; m_lk = 1'b0;
   endtask

   task automatic model_step(input bit st, input bit v, input bit a, input bit b,
                             input bit q, input bit nq);
      logic [3:0] nc;
      if (st) begin
         m_st = M_SEARCH; m_cand = 4'b1111; m_smp = 0; m_run = 0;
         m_sel = 2'b00; m_code = 2'b00; m_lk = 1'b0;
      end else if (v && m_st == M_SEARCH) begin
         if (q == nq) begin
            m_st = M_ERROR; m_code = 2'b01;
         end else begin
            nc = 4'b0000;
            for (int c = 0; c < 4; c++)
               if (m_cand[c] && sel_fn(c, a, b) == q) nc[c] = 1'b1;
            m_cand = nc;
            if (nc == 4'b0000) begin
               m_st = M_ERROR; m_code = 2'b10;
            end else begin
               m_smp++;
               m_run = ($countones(nc) == 1) ? m_run + 1 : 0;
               if (m_run == LK) begin
                  m_st = M_LOCKED; m_lk = 1'b1;
                  for (int c = 0; c < 4; c++) if (nc[c]) m_sel = 2'(c);
               end else if (m_smp == MX) begin
                  m_st = M_ERROR; m_code = 2'b11;
               end
            end
         end
      end else if (v && m_st == M_LOCKED) begin
         if (q == nq) begin
            m_st = M_ERROR; m_code = 2'b01; m_lk = 1'b0;
         end else if (sel_fn(int'(m_sel), a, b) != q) begin
            m_st = M_ERROR; m_code = 2'b10; m_lk = 1'b0;
         end
      end
   endtask

   task automatic chk_all(input string tag);
      chk({tag, ".cand"},     32'(bus_if.cand),     32'(m_cand));
      chk({tag, ".sel_out"},  32'(bus_if.sel_out),  32'(m_sel));
      chk({tag, ".locked"},   32'(bus_if.locked),   32'(m_lk));
      chk({tag, ".busy"},     32'(bus_if.busy),     32'(m_st == M_SEARCH));
      chk({tag, ".error"},    32'(bus_if.error),    32'(m_st == M_ERROR));
      chk({tag, ".err_code"}, 32'(bus_if.err_code), 32'(m_code));
   endtask

   task automatic cyc(input string tag, input bit st, input bit v, input bit a, input bit b,
                      input bit q, input bit nq);
      @(negedge clk);
      bus_if.start = st; bus_if.valid = v;
      bus_if.a = a; bus_if.b = b; bus_if.q = q; bus_if.nq = nq;
      @(posedge clk);
      model_step(st, v, a, b, q, nq);
      #1;
      chk_all(tag);
   endtask

   initial begin
      int  tsel;
      bit  ra, rb, rq, rnq, rst_v, rv;

      bus_if.start = 1'b0; bus_if.valid = 1'b0;
      bus_if.a = 1'b0; bus_if.b = 1'b0; bus_if.q = 1'b0; bus_if.nq = 1'b0;
      rst_n = 1'b0;
      model_reset();
      #12;
      chk_all("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Samples in IDLE are ignored.
      cyc("idle_valid", 0, 1, 1, 0, 1, 0);
      chk("idle_cand", 32'(bus_if.cand), 32'hF);

      // Lock on sel 00.
      cyc("l00_start", 1, 0, 0, 0, 0, 0);
      cyc("l00_s1", 0, 1, 1, 0, 1, 0);
      chk("l00_cand1", 32'(bus_if.cand), 32'h9);
      cyc("l00_s2", 0, 1, 0, 1, 0, 1);
      chk("l00_cand2", 32'(bus_if.cand), 32'h1);
      cyc("l00_s3", 0, 1, 1, 1, 1, 0);
      cyc("l00_s4", 0, 1, 1, 0, 1, 0);
      chk("l00_notyet", 32'(bus_if.locked), 32'h0);
      cyc("l00_s5", 0, 1, 0, 0, 0, 1);
      chk("l00_locked", 32'(bus_if.locked), 32'h1);
      chk("l00_sel", 32'(bus_if.sel_out), 32'h0);
      chk("l00_busy", 32'(bus_if.busy), 32'h0);

      // Start together with a mismatching valid while locked: sample dropped.
      cyc("stv", 1, 1, 1, 0, 0, 1);
      chk("stv_cand", 32'(bus_if.cand), 32'hF);
      chk("stv_busy", 32'(bus_if.busy), 32'h1);
      chk("stv_locked", 32'(bus_if.locked), 32'h0);

      // Lock on sel 10, then a locked mismatch.
      cyc("l10_s1", 0, 1, 1, 0, 0, 1);
      cyc("l10_s2", 0, 1, 0, 1, 0, 1);
      for (int i = 0; i < 3; i++) cyc("l10_rep", 0, 1, 1, 1, 1, 0);
      chk("l10_locked", 32'(bus_if.locked), 32'h1);
      chk("l10_sel", 32'(bus_if.sel_out), 32'h2);
      cyc("l10_gap", 0, 0, 1, 1, 0, 1);
      chk("l10_gap_locked", 32'(bus_if.locked), 32'h1);
      cyc("l10_bad", 0, 1, 1, 1, 0, 1);
      chk("l10_err", 32'(bus_if.error), 32'h1);
      chk("l10_code", 32'(bus_if.err_code), 32'h2);
      chk("l10_unlock", 32'(bus_if.locked), 32'h0);
      chk("l10_selhold", 32'(bus_if.sel_out), 32'h2);
      cyc("err_hold", 0, 1, 1, 0, 1, 0);
      chk("err_hold_code", 32'(bus_if.err_code), 32'h2);

      // Complement violation.
      cyc("cmp_start", 1, 0, 0, 0, 0, 0);
      cyc("cmp_bad", 0, 1, 1, 1, 1, 1);
      chk("cmp_err", 32'(bus_if.error), 32'h1);
      chk("cmp_code", 32'(bus_if.err_code), 32'h1);
      chk("cmp_busy", 32'(bus_if.busy), 32'h0);

      // Timeout on ambiguous samples.
      cyc("to_start", 1, 0, 0, 0, 0, 0);
      for (int i = 0; i < MX - 1; i++) cyc("to_s", 0, 1, 0, 0, 0, 1);
      chk("to_pre_err", 32'(bus_if.error), 32'h0);
      cyc("to_last", 0, 1, 0, 0, 0, 1);
      chk("to_cand", 32'(bus_if.cand), 32'hF);
      chk("to_code", 32'(bus_if.err_code), 32'h3);

      // Asynchronous reset mid-SEARCH.
      cyc("rs_start", 1, 0, 0, 0, 0, 0);
      cyc("rs_s1", 0, 1, 1, 0, 0, 1);
      cyc("rs_s2", 0, 1, 0, 1, 1, 0);
      chk("rs_cand", 32'(bus_if.cand), 32'h2);
      #2 rst_n = 1'b0;
      #1;
      model_reset();
      chk_all("rs_async");
      chk("rs_busy", 32'(bus_if.busy), 32'h0);
      rst_n = 1'b1;
      cyc("rs_ignore", 0, 1, 0, 1, 0, 1);
      chk("rs_ignore_cand", 32'(bus_if.cand), 32'hF);

      // Random streams from a chosen select code with occasional faults and restarts.
      tsel = 0;
      for (int i = 0; i < 600; i++) begin
         rst_v = ($urandom_range(0, 24) == 0);
         if (rst_v) tsel = $urandom_range(0, 3);
         rv  = ($urandom_range(0, 3) != 0);
         ra  = 1'($urandom);
         rb  = 1'($urandom);
         rq  = sel_fn(tsel, ra, rb);
         if ($urandom_range(0, 29) == 0) rq = ~rq;
         rnq = ($urandom_range(0, 39) == 0) ? rq : ~rq;
         cyc("rand", rst_v, rv, ra, rb, rq, rnq);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
